// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop and lap/clear FSM driving a mm:ss BCD counter with registered display digits.
// Optional feature macro: STOPWATCH_LAP_EN enables the LAP state and display hold.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_start,
    input  logic       pb_lap,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [9:0] PCNT_TOP = 10'(TICK_DIV - 1);

    state_t      cur;
    logic [9:0]  pcnt;
    logic [15:0] live;      // {min_tens, min_ones, sec_tens, sec_ones}
    logic [15:0] disp;
    logic [15:0] nxt;
    logic        counting;
    logic        tick;
    logic        rollover;
    logic        wrap_q;

    assign state = cur;
    assign wrap  = wrap_q;
    assign {min_tens, min_ones, sec_tens, sec_ones} = disp;

    // Live time one second ahead when this edge carries a tick; feeds both live and display.
    always_comb begin
        counting = (cur == RUN) || (cur == LAP);
        tick     = counting && (pcnt == PCNT_TOP);
        nxt      = live;
        rollover = 1'b0;
        if (tick) begin
            if (live[3:0] == 4'd9) begin
                nxt[3:0] = 4'd0;
                if (live[7:4] == 4'd5) begin
                    nxt[7:4] = 4'd0;
                    if (live[11:8] == 4'd9) begin
                        nxt[11:8] = 4'd0;
                        if (live[15:12] == 4'd5) begin
                            nxt[15:12] = 4'd0;
                            rollover   = 1'b1;
                        end else begin
                            nxt[15:12] = live[15:12] + 4'd1;
                        end
                    end else begin
                        nxt[11:8] = live[11:8] + 4'd1;
                    end
                end else begin
                    nxt[7:4] = live[7:4] + 4'd1;
                end
            end else begin
                nxt[3:0] = live[3:0] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur    <= IDLE;
            pcnt   <= '0;
            live   <= '0;
            disp   <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= rollover;
            live   <= nxt;
            if (counting) begin
                pcnt <= tick ? '0 : pcnt + 10'd1;
            end
            if (cur != LAP) begin
                disp <= nxt;
            end

            // pb_start is tested first everywhere, so a simultaneous pb_lap is dropped.
            case (cur)
                IDLE: begin
                    if (pb_start) begin
                        cur  <= RUN;
                        pcnt <= '0;
                    end
                end
                RUN: begin
                    if (pb_start) begin
                        cur <= PAUSE;
`ifdef STOPWATCH_LAP_EN
                    end else if (pb_lap) begin
                        cur <= LAP;
`endif
                    end
                end
                PAUSE: begin
                    if (pb_start) begin
                        cur <= RUN;
                    end else if (pb_lap) begin
                        cur  <= IDLE;
                        live <= '0;
                        disp <= '0;
                        pcnt <= '0;
                    end
                end
                LAP: begin
                    if (pb_start) begin
                        cur  <= PAUSE;
                        disp <= nxt;
                    end else if (pb_lap) begin
                        cur  <= RUN;
                        disp <= nxt;
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule
